// File: rtl/audio_pdm_modulator.sv
// rtl/audio_pdm_modulator.sv - PCM sample FIFO, rate-control FSM and second-order PDM modulator
module audio_pdm_modulator #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] pcm_in,
    input  logic               pcm_valid,
    output logic               pcm_ready,
    input  logic               stb_pcm,
    input  logic               stb_sample,
    output logic               pdm_out,
    output logic               underrun,
    output logic               clip
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [15:0]  LVL_MAX = 16'sd24575;
    localparam logic signed [15:0]  LVL_MIN = -16'sd24576;
    localparam logic signed [W-1:0] FB_POS  = W'(32768);
    localparam logic signed [W-1:0] FB_NEG  = -FB_POS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_STARVED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [15:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ready_q, ready_d;
    logic signed [15:0] level_q, level_d;
    logic               underrun_q, underrun_d;
    logic               clip_q, clip_d;
    logic signed [W-1:0] i1_q, i1_d;
    logic signed [W-1:0] i2_q, i2_d;
    logic               pdm_q, pdm_d;

    logic               push, pop;
    logic signed [15:0] head, head_clamped;
    logic               head_clips;
    logic signed [W-1:0] level_ext, fb, i1_step, i2_step;

    // Sample storage carries no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pcm_in;
        end
    end

    always_comb begin
        push         = pcm_valid && ready_q;
        pop          = 1'b0;
        state_d      = state_q;
        level_d      = level_q;
        underrun_d   = underrun_q;
        clip_d       = clip_q;
        head         = mem_q[rd_ptr_q];
        head_clamped = head;
        head_clips   = 1'b0;
        if (head > LVL_MAX) begin
            head_clamped = LVL_MAX;
            head_clips   = 1'b1;
        end else if (head < LVL_MIN) begin
            head_clamped = LVL_MIN;
            head_clips   = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                level_d = '0;
                if (stb_pcm && count_q >= CW'(2)) begin
                    pop     = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stb_pcm) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_STARVED;
                    end
                end
            end
            S_STARVED: begin
                if (stb_pcm && count_q >= CW'(2)) begin
                    pop     = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            level_d = head_clamped;
            if (head_clips) begin
                clip_d = 1'b1;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // Ready tracks the post-update count so a full FIFO never sees a push.
        ready_d = (count_d < CW'(DEPTH));
    end

    // Modulator consumes level_q, i.e. the level held before any pop this cycle.
    always_comb begin
        level_ext = {{(W-16){level_q[15]}}, level_q};
        fb        = pdm_q ? FB_POS : FB_NEG;
        i1_step   = i1_q + level_ext - fb;
        i2_step   = i2_q + i1_step - fb;
        i1_d      = i1_q;
        i2_d      = i2_q;
        pdm_d     = pdm_q;
        if (stb_sample) begin
            i1_d  = i1_step;
            i2_d  = i2_step;
            pdm_d = ~i2_step[W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            level_q    <= '0;
            underrun_q <= 1'b0;
            clip_q     <= 1'b0;
            i1_q       <= '0;
            i2_q       <= '0;
            pdm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
            clip_q     <= clip_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            pdm_q      <= pdm_d;
        end
    end

    assign pcm_ready = ready_q;
    assign pdm_out   = pdm_q;
    assign underrun  = underrun_q;
    assign clip      = clip_q;
endmodule

// File: tb/tb_audio_pdm_modulator.sv
// tb/tb_audio_pdm_modulator.sv - directed self-checking bench for audio_pdm_modulator
module tb_audio_pdm_modulator;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] pcm_in;
    logic               pcm_valid;
    logic               pcm_ready;
    logic               stb_pcm;
    logic               stb_sample;
    logic               pdm_out;
    logic               underrun;
    logic               clip;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ones     = 0;
    int pcm_period = 2000;
    logic               feed_en  = 1'b0;
    logic signed [15:0] feed_val = '0;

    always #5 clk = ~clk;

    audio_pdm_modulator #(.W(24), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .stb_pcm    (stb_pcm),
        .stb_sample (stb_sample),
        .pdm_out    (pdm_out),
        .underrun   (underrun),
        .clip       (clip)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Strobes every 16 clk; stb_pcm every pcm_period clk; producer pushes while feed_en.
    task automatic run_auto(input int n, input bit count_en);
        for (int k = 0; k < n; k++) begin
            stb_sample = (cyc % 16 == 0);
            stb_pcm    = (cyc % pcm_period == 0);
            pcm_valid  = feed_en;
            pcm_in     = feed_val;
            tick();
            if (count_en && stb_sample) ones += int'(pdm_out);
            cyc++;
        end
        stb_sample = 1'b0;
        stb_pcm    = 1'b0;
        pcm_valid  = 1'b0;
    endtask

    task automatic push(input logic signed [15:0] v);
        pcm_in    = v;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
    endtask

    task automatic pulse_pcm();
        stb_pcm = 1'b1;
        tick();
        stb_pcm = 1'b0;
    endtask

    task automatic do_reset();
        feed_en    = 1'b0;
        stb_pcm    = 1'b0;
        stb_sample = 1'b0;
        pcm_valid  = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_stream(input logic signed [15:0] v);
        do_reset();
        for (int k = 0; k < 4; k++) push(v);
        feed_val   = v;
        feed_en    = 1'b1;
        pcm_period = 2000;
        cyc        = 0;
        ones       = 0;
    endtask

    initial begin
        rst        = 1'b1;
        pcm_in     = '0;
        pcm_valid  = 1'b0;
        stb_pcm    = 1'b0;
        stb_sample = 1'b0;
        tick();
        tick();
        check("rst_pdm", pdm_out, 0);
        check("rst_ready", pcm_ready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_clip", clip, 0);
        check("rst_level", dut.level_q, 0);
        rst = 1'b0;
        check("ready_before_edge", pcm_ready, 0);
        tick();
        check("ready_after_release", pcm_ready, 1);

        for (int k = 0; k < 4; k++) push(16'sd0);
        check("ready_full", pcm_ready, 0);
        pcm_in    = 16'sd32767;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
        check("ready_full_hold", pcm_ready, 0);

        // Zero level: 50% density
        feed_val = 16'sd0;
        feed_en  = 1'b1;
        cyc = 0; ones = 0; pcm_period = 2000;
        run_auto(16, 0);
        run_auto(16000, 1);
        check_range("ones_zero", ones, 498, 502);
        check("clip_zero", clip, 0);
        check("underrun_zero", underrun, 0);

        start_stream(16'sd16384);
        run_auto(16, 0);
        check("level_16384", dut.level_q, 16384);
        run_auto(16000, 1);
        check_range("ones_16384", ones, 748, 752);
        check("clip_16384", clip, 0);

        start_stream(16'sd32767);
        run_auto(1, 0);
        check("clip_pos_full", clip, 1);
        check("level_pos_full", dut.level_q, 24575);
        run_auto(15, 0);
        run_auto(16000, 1);
        check_range("ones_pos_full", ones, 873, 877);

        start_stream(-16'sd32768);
        run_auto(16, 0);
        check("level_neg_full", dut.level_q, -24576);
        run_auto(16000, 1);
        check_range("ones_neg_full", ones, 123, 127);
        check("clip_neg_full", clip, 1);

        // Clamp boundaries
        do_reset(); push(16'sd24575); push(16'sd24575); pulse_pcm();
        check("lvl_24575", dut.level_q, 24575);
        check("clip_24575", clip, 0);
        do_reset(); push(-16'sd24576); push(-16'sd24576); pulse_pcm();
        check("lvl_m24576", dut.level_q, -24576);
        check("clip_m24576", clip, 0);
        do_reset(); push(16'sd24576); push(16'sd24576); pulse_pcm();
        check("lvl_24576", dut.level_q, 24575);
        check("clip_24576", clip, 1);
        do_reset(); push(-16'sd24577); push(-16'sd24577); pulse_pcm();
        check("lvl_m24577", dut.level_q, -24576);
        check("clip_m24577", clip, 1);

        // Coincident strobes use the pre-pop level (0)
        do_reset();
        for (int k = 0; k < 4; k++) push(16'sd24575);
        stb_pcm = 1'b1; stb_sample = 1'b1;
        tick();
        stb_pcm = 1'b0; stb_sample = 1'b0;
        check("coincide_i1", dut.i1_q, 32768);
        check("coincide_pdm", pdm_out, 1);
        stb_sample = 1'b1;
        tick();
        stb_sample = 1'b0;
        check("step2_i1", dut.i1_q, 24575);
        check("step2_i2", dut.i2_q, 57343);
        tick();
        tick();
        check("hold_i1", dut.i1_q, 24575);

        // Underrun and recovery
        do_reset();
        push(16'sd100); push(16'sd200); push(16'sd300);
        feed_en = 1'b0; pcm_period = 64; cyc = 0;
        run_auto(150, 0);
        check("pre_underrun_level", dut.level_q, 300);
        check("pre_underrun_flag", underrun, 0);
        run_auto(60, 0);
        check("underrun_set", underrun, 1);
        check("starved_level", dut.level_q, 300);
        push(16'sd400); pulse_pcm();
        check("starved_one_entry", dut.level_q, 300);
        push(16'sd500); pulse_pcm();
        check("resume_level", dut.level_q, 400);
        pulse_pcm();
        check("run_pop_last", dut.level_q, 500);
        pulse_pcm();
        check("underrun2_level", dut.level_q, 500);
        check("underrun_sticky", underrun, 1);

        // Reset mid-stream with 3 entries queued
        do_reset();
        for (int k = 0; k < 4; k++) push(16'sd30000);
        pulse_pcm();
        pcm_period = 2000; cyc = 1;
        run_auto(40, 0);
        check("mid_clip_before", clip, 1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_pdm", pdm_out, 0);
        check("mid_rst_ready", pcm_ready, 0);
        check("mid_rst_clip", clip, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_level", dut.level_q, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("mid_ready_back", pcm_ready, 1);
        push(16'sd1234); pulse_pcm();
        check("mid_fifo_discarded", dut.level_q, 0);
        check("mid_idle_no_underrun", underrun, 0);
        push(16'sd2345); pulse_pcm();
        check("mid_first_pop", dut.level_q, 1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_pdm_modulator.md
AUDIO_PDM_MODULATOR -- requirements
Module: audio_pdm_modulator

Interface
REQ-001 SHALL have parameter W, default 24: width of the modulator integrators, in bits.
REQ-002 SHALL have parameter DEPTH, default 4: depth of the PCM input FIFO, in entries (a power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pcm_in, input, 16 bits, signed: PCM sample from the producer.
REQ-006 SHALL have port pcm_valid, input, 1 bit: pcm_in holds a sample.
REQ-007 SHALL have port pcm_ready, output, 1 bit: the FIFO can accept a sample.
REQ-008 SHALL have port stb_pcm, input, 1 bit: one-cycle strobe at the PCM rate; the FIFO pops on it.
REQ-009 SHALL have port stb_sample, input, 1 bit: one-cycle strobe at the PDM bit rate; the modulator steps on it.
REQ-010 SHALL have port pdm_out, output, 1 bit: PDM bitstream to the output filter or amplifier.
REQ-011 SHALL have port underrun, output, 1 bit: sticky flag, set when a pop finds the FIFO empty while in RUN.
REQ-012 SHALL have port clip, output, 1 bit: sticky flag, set when a sample is clamped.

Function
REQ-013 The FIFO SHALL accept a push on any cycle where pcm_valid && pcm_ready; pcm_ready SHALL equal (count < DEPTH), registered.
REQ-014 Simultaneous push and pop SHALL leave count unchanged; a push on a full FIFO is impossible because pcm_ready is low then.
REQ-015 A push and a pop arriving in the same cycle on an empty FIFO SHALL be treated as a pop of an empty FIFO; the pushed sample is stored and count becomes 1.
REQ-016 The FSM SHALL have states IDLE, RUN and STARVED; reset SHALL enter IDLE.
REQ-017 In IDLE, the FSM SHALL move to RUN on the first stb_pcm seen with count >= 2, popping one sample on that strobe.
REQ-018 In RUN, each stb_pcm SHALL pop one sample into the level register; a pop with count == 0 SHALL set underrun, hold the previous level, and move to STARVED.
REQ-019 In STARVED, the FSM SHALL return to RUN on the first stb_pcm seen with count >= 2 (pop on that strobe); the level SHALL be held meanwhile.
REQ-020 In IDLE, the level register SHALL be 0.
REQ-021 A popped sample SHALL be clamped to [-24576, +24575] before entering the level register; any clamp SHALL set clip.
REQ-022 The level register SHALL change only on a stb_pcm pop (zero-order hold between pops).
REQ-023 The modulator SHALL be second order, stepping on stb_sample: fb = pdm_out ? +32768 : -32768; i1 <= i1 + level - fb; i2 <= i2 + i1_next - fb.
REQ-024 pdm_out SHALL be registered as (i2_next >= 0), updating in the cycle after stb_sample; all arithmetic SHALL be signed W-bit with sign-extended operands.
REQ-025 pdm_out, i1 and i2 SHALL hold when stb_sample is low.
REQ-026 When stb_pcm and stb_sample coincide, the modulator SHALL use the level value from before that cycle's pop.
REQ-027 Over N strobes, the ones density of pdm_out SHALL equal (1 + level/32768)/2 within ±2 counts.

Reset
REQ-028 While rst is asserted, the block SHALL force pdm_out=0, pcm_ready=0, underrun=0, clip=0, count=0, level=0, i1=0, i2=0 and state=IDLE.
REQ-029 pcm_ready SHALL rise on the first clk edge after rst is released.
REQ-030 Asserting rst mid-stream SHALL discard the FIFO contents immediately, with no partial pop.
REQ-031 The underrun and clip flags SHALL clear only on rst.

Verification
REQ-032 Reset, then push 0x0000 four times, stb_pcm every 125 stb_sample (16 clk each) -> RUN entered; over 1000 strobes, ones count 500±2.
REQ-033 Stream constant +16384 -> ones count 750±2 per 1000 strobes; clip stays 0.
REQ-034 Stream +32767 -> clip=1 after the first pop; level=24575; ones count 875±2 per 1000 strobes.
REQ-035 Push 4 samples with stb_pcm low -> pcm_ready=0 the cycle after the 4th push; the 5th pcm_valid is not accepted.
REQ-036 Stop pushing in RUN -> pop on empty sets underrun=1 and state STARVED with level held; push 2 samples -> resume RUN on the next stb_pcm.
REQ-037 Assert rst mid-stream with the FIFO at 3 entries -> all outputs at reset values while asserted; after release, behaviour matches a fresh reset.
